// File: rtl/prog_loader.sv
// Streams host bytes into instruction memory, holding the CPU in reset until the image is loaded.
// Define PROG_LOADER_CHECKSUM_EN to add a trailing mod-256 checksum byte and the CHECK/ERR path.
module prog_loader #(
   parameter int LAST_ADDR = 31
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic       start_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_data_i,
   output logic       byte_ready_o,
   output logic       mem_we_o,
   output logic [4:0] mem_addr_o,
   output logic [7:0] mem_data_o,
   output logic       cpu_rst_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   // state | meaning
   // IDLE  | out of reset, waiting for start_i
   // LOAD  | accepting data bytes, one write per accepted byte
   // FLUSH | final write strobe on its way out (no checksum build)
   // CHECK | final write strobe, then waiting for the checksum byte
   // DONE  | image loaded, CPU released
   // ERR   | checksum mismatch, CPU stays in reset
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK,
`endif
      DONE,
      ERR
   } state_t;

   localparam logic [4:0] LAST = LAST_ADDR[4:0];

   state_t     state_q;
   state_t     state_d;
   logic [4:0] cnt_q;
   logic       accept;
   logic       restart;

   assign accept  = byte_valid_i && byte_ready_o;
   assign restart = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] sum_chk;

   assign sum_chk      = sum_q + byte_data_i;
   assign byte_ready_o = (state_q == LOAD) || (state_q == CHECK);
   assign busy_o       = (state_q == LOAD) || (state_q == FLUSH) || (state_q == CHECK);

   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         sum_q <= 8'h00;
      end else if (restart) begin
         sum_q <= 8'h00;
      end else if (state_q == LOAD && accept) begin
         sum_q <= sum_chk;
      end
   end
`else
   assign byte_ready_o = (state_q == LOAD);
   assign busy_o       = (state_q == LOAD) || (state_q == FLUSH);
`endif

   assign cpu_rst_o = (state_q != DONE);
   assign done_o    = (state_q == DONE);
   assign err_o     = (state_q == ERR);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start_i) state_d = LOAD;
         end
         LOAD: begin
            if (accept && cnt_q == LAST) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = FLUSH;
`endif
            end
         end
         FLUSH: state_d = DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) state_d = (sum_chk == 8'h00) ? DONE : ERR;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // The write port is registered, so the strobe lands one cycle after acceptance.
   always_ff @(posedge clk_i or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 5'd0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= 5'd0;
         mem_data_o <= 8'h00;
      end else begin
         state_q  <= state_d;
         mem_we_o <= 1'b0;
         if (restart) begin
            cnt_q <= 5'd0;
         end else if (state_q == LOAD && accept) begin
            mem_we_o   <= 1'b1;
            mem_addr_o <= cnt_q;
            mem_data_o <= byte_data_i;
            if (cnt_q != LAST) cnt_q <= cnt_q + 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; also covers the PROG_LOADER_CHECKSUM_EN build.
module tb_prog_loader;

   logic       clk_i = 1'b0;
   logic       reset = 1'b1;
   logic       start_i = 1'b0;
   logic       byte_valid_i = 1'b0;
   logic [7:0] byte_data_i = 8'h00;
   logic       byte_ready_o;
   logic       mem_we_o;
   logic [4:0] mem_addr_o;
   logic [7:0] mem_data_o;
   logic       cpu_rst_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   int n_pass = 0;
   int n_total = 0;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit         CHK = 1'b1;
`else
   localparam bit         CHK = 1'b0;
`endif
   // checksum for bytes 0x00..0x1F: sum = 0xF0
   localparam logic [7:0] CKS = 8'h10;

   prog_loader #(.LAST_ADDR(31)) dut (
      .clk_i(clk_i), .reset(reset), .start_i(start_i),
      .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
      .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       start;
      logic       valid;
      logic [7:0] din;
      logic       ready;
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic       crst;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk_all(input string name, input logic ready, input logic we,
                          input logic [4:0] addr, input logic [7:0] wdata,
                          input logic crst, input logic busy, input logic done,
                          input logic err);
      chk({name, ".ready"}, byte_ready_o, ready);
      chk({name, ".we"}, mem_we_o, we);
      chk({name, ".addr"}, mem_addr_o, addr);
      chk({name, ".data"}, mem_data_o, wdata);
      chk({name, ".cpu_rst"}, cpu_rst_o, crst);
      chk({name, ".busy"}, busy_o, busy);
      chk({name, ".done"}, done_o, done);
      chk({name, ".err"}, err_o, err);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
      @(negedge clk_i);
      reset = 1'b0;
   endtask

   initial begin
      // valid toggling and a start pulse in the middle of LOAD
      vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 5'd0, 8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd1, 8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 5'd1, 8'hA5, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 5'd2, 8'h3C, 1'b1, 1'b1, 1'b0};

      #2;
      chk_all("reset", 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         start_i = vecs[i].start; byte_valid_i = vecs[i].valid; byte_data_i = vecs[i].din;
         chk_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].we, vecs[i].addr,
                 vecs[i].wdata, vecs[i].crst, vecs[i].busy, vecs[i].done, 1'b0);
      end

      // full 32-byte image with valid held high
      do_reset();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int k = 0; k < 32; k++) begin
         byte_valid_i = 1'b1; byte_data_i = 8'(k);
         chk($sformatf("full%0d.ready", k), byte_ready_o, 1'b1);
         chk($sformatf("full%0d.we", k), mem_we_o, (k > 0));
         if (k > 0) begin
            chk($sformatf("full%0d.addr", k), mem_addr_o, 32'(k - 1));
            chk($sformatf("full%0d.data", k), mem_data_o, 32'(k - 1));
         end
         @(negedge clk_i);
      end
      byte_data_i = CKS;
      chk_all("flush", CHK, 1'b1, 5'd31, 8'h1F, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk_i);
      byte_valid_i = 1'b1; byte_data_i = 8'hFF;
      chk_all("done", 1'b0, 1'b0, 5'd31, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      chk_all("done_hold", 1'b0, 1'b0, 5'd31, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0);

      // restart from DONE
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk_all("restart", 1'b1, 1'b0, 5'd31, 8'h1F, 1'b1, 1'b1, 1'b0, 1'b0);

      // ten bytes, then reset while the tenth strobe is out
      for (int k = 0; k < 10; k++) begin
         byte_valid_i = 1'b1; byte_data_i = 8'h40 + 8'(k);
         @(negedge clk_i);
      end
      byte_valid_i = 1'b0;
      chk("midload.we", mem_we_o, 1'b1);
      chk("midload.addr", mem_addr_o, 5'd9);
      chk("midload.data", mem_data_o, 8'h49);
      reset = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("rst_hold.we", mem_we_o, 1'b0);
      reset = 1'b0;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; byte_valid_i = 1'b1; byte_data_i = 8'h77;
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      chk("reload.we", mem_we_o, 1'b1);
      chk("reload.addr", mem_addr_o, 5'd0);
      chk("reload.data", mem_data_o, 8'h77);

`ifdef PROG_LOADER_CHECKSUM_EN
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         start_i = 1'b1;
         @(negedge clk_i);
         start_i = 1'b0;
         for (int k = 0; k < 32; k++) begin
            byte_valid_i = 1'b1; byte_data_i = 8'h01;
            @(negedge clk_i);
         end
         byte_data_i = (pass == 0) ? 8'hE0 : 8'hE1;
         chk($sformatf("cks%0d.check_we", pass), mem_we_o, 1'b1);
         chk($sformatf("cks%0d.check_ready", pass), byte_ready_o, 1'b1);
         @(negedge clk_i);
         byte_valid_i = 1'b0;
         chk($sformatf("cks%0d.done", pass), done_o, (pass == 0));
         chk($sformatf("cks%0d.err", pass), err_o, (pass == 1));
         chk($sformatf("cks%0d.cpu_rst", pass), cpu_rst_o, (pass == 1));
         chk($sformatf("cks%0d.we", pass), mem_we_o, 1'b0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter LAST_ADDR, default 31, meaning the highest instruction-memory address loaded (5-bit range, 0..31).
REQ-002 The module SHALL have port clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port start_i  input  1  begin a load when high in IDLE, DONE or ERR.
REQ-005 The module SHALL have port byte_valid_i  input  1  host byte available.
REQ-006 The module SHALL have port byte_data_i  input  8  host byte value.
REQ-007 The module SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-008 The module SHALL have port mem_we_o  output  1  instruction-memory write strobe.
REQ-009 The module SHALL have port mem_addr_o  output  5  instruction-memory write address.
REQ-010 The module SHALL have port mem_data_o  output  8  instruction-memory write data.
REQ-011 The module SHALL have port cpu_rst_o  output  1  holds the CPU in reset while high.
REQ-012 The module SHALL have ports busy_o, done_o and err_o  output  1 each  status flags.

Function
REQ-013 The module SHALL implement states IDLE, LOAD, FLUSH, CHECK (CHECKSUM_EN only), DONE and ERR.
REQ-014 In IDLE, DONE or ERR, start_i=1 SHALL move the state to LOAD on the next edge and clear the address counter to 0.
REQ-015 In LOAD or FLUSH, start_i SHALL be ignored.
REQ-016 byte_ready_o SHALL be 1 only in LOAD and CHECK, decoded from the state register, with no combinational path from any input.
REQ-017 A byte SHALL be accepted on an edge where byte_valid_i=1 and byte_ready_o=1; byte_valid_i without ready SHALL have no effect.
REQ-018 Each byte accepted in LOAD SHALL produce exactly one mem_we_o=1 cycle on the cycle after acceptance, with mem_addr_o = counter value at acceptance and mem_data_o = the accepted byte.
REQ-019 After each accepted byte, the counter SHALL increment by 1; back-to-back bytes (valid held high) SHALL be accepted every cycle.
REQ-020 Accepting the byte at address LAST_ADDR SHALL move the state to FLUSH (no CHECKSUM_EN) or CHECK (CHECKSUM_EN); the counter SHALL NOT wrap, and no further data bytes are accepted.
REQ-021 FLUSH SHALL last one cycle, carry the final write strobe, and then move to DONE.
REQ-022 mem_we_o SHALL be 0 in every cycle not covered by REQ-018; mem_addr_o and mem_data_o SHALL hold their last value when no write occurs.
REQ-023 cpu_rst_o SHALL be 1 in every state except DONE.
REQ-024 busy_o SHALL be 1 in LOAD, FLUSH and CHECK; done_o SHALL be 1 only in DONE; err_o SHALL be 1 only in ERR.
REQ-025 start_i in DONE SHALL reassert cpu_rst_o on the next edge, because the state returns to LOAD.

Reset
REQ-026 Reset asserted at any time, including mid-load, SHALL asynchronously force: state IDLE, counter 0, mem_we_o 0, mem_addr_o 0, mem_data_o 0, byte_ready_o 0, cpu_rst_o 1, busy_o/done_o/err_o 0.
REQ-027 A write strobe pending at reset assertion SHALL be discarded.

Configuration
REQ-028 With macro PROG_LOADER_CHECKSUM_EN defined, the module SHALL keep an 8-bit running sum (mod 256) of all data bytes, cleared when LOAD is entered.
REQ-029 With the macro defined, in CHECK, the final data write SHALL occur in the first CHECK cycle.
REQ-030 With the macro defined, the next accepted byte in CHECK is the checksum: sum+checksum == 8'h00 SHALL move the state to DONE, and any other value SHALL move it to ERR.
REQ-031 With the macro undefined, the module SHALL contain no CHECK state and no sum logic, and ERR SHALL be unreachable.

Verification
REQ-032 Reset, then start_i pulse, then 32 bytes 8'h00..8'h1F with valid held high -> 32 consecutive single-cycle strobes with addr=data=n; FLUSH; done_o=1; cpu_rst_o falls one cycle after the last strobe.
REQ-033 Valid toggled 1,0,1,0 with byte 8'hA5 -> strobe only after valid cycles; address increments only on acceptance.
REQ-034 Reset asserted after 10 bytes -> all outputs at reset values immediately; a new start_i reloads from address 0.
REQ-035 start_i pulse in DONE -> cpu_rst_o=1 and busy_o=1 on the next cycle; counter is 0.
REQ-036 CHECKSUM_EN, 32 bytes of 8'h01, checksum 8'hE0 -> done_o=1; checksum 8'hE1 -> err_o=1 and cpu_rst_o stays 1.
REQ-037 start_i pulsed mid-LOAD -> ignored; the load completes normally.
